// File: rtl/aq_falu_pkg.sv
// Shared owner encoding, tag width and stage record for the FALU issue pipeline.
// Pure declarations; no latency or backpressure of its own.
package aq_falu_pkg;

    localparam int TAG_W  = 4;
    localparam int STAGES = 3;
    localparam int CNT_W  = $clog2(STAGES + 1);

    typedef enum logic {
        OWN_FPU = 1'b0,
        OWN_VPU = 1'b1
    } owner_e;

    typedef struct packed {
        logic             vld;
        owner_e           owner;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic logic owner_rdy(input owner_e owner, input logic fpu_rdy, input logic vpu_rdy);
        return (owner == OWN_VPU) ? vpu_rdy : fpu_rdy;
    endfunction

endpackage

// File: rtl/aq_falu_rr_arb.sv
// Two-way round-robin arbiter between FPU and VPU issue; combinational grant.
// Grants only when en is high; pointer moves to the loser after each grant, holds otherwise.
module aq_falu_rr_arb
    import aq_falu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   fpu_req,
    input  logic   vpu_req,
    output logic   fpu_gnt,
    output logic   vpu_gnt,
    output owner_e rr
);

    always_comb begin
        fpu_gnt = 1'b0;
        vpu_gnt = 1'b0;
        if (en) begin
            if (fpu_req && vpu_req) begin
                fpu_gnt = (rr == OWN_FPU);
                vpu_gnt = (rr == OWN_VPU);
            end else begin
                fpu_gnt = fpu_req;
                vpu_gnt = vpu_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= OWN_FPU;
        end else if (fpu_gnt) begin
            rr <= OWN_VPU;
        end else if (vpu_gnt) begin
            rr <= OWN_FPU;
        end
    end

endmodule

// File: rtl/aq_falu_pipe_sched.sv
// Three-stage FALU scheduler shared by scalar FPU and vector VPU; grant to result is 3 cycles.
// An unready owner stalls ex3 and the stall ripples back only through occupied stages.
module aq_falu_pipe_sched
    import aq_falu_pkg::*;
(
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             fpu_req_vld,
    input  logic [TAG_W-1:0] fpu_req_tag,
    input  logic             vpu_req_vld,
    input  logic [TAG_W-1:0] vpu_req_tag,
    output logic             fpu_req_gnt,
    output logic             vpu_req_gnt,
    output logic             fpu_res_vld,
    output logic             vpu_res_vld,
    output logic [TAG_W-1:0] res_tag,
    input  logic             fpu_res_rdy,
    input  logic             vpu_res_rdy,
    input  logic             falu_flush,
    input  logic             ifu_vpu_warm_up,
    output logic             fadd_ex1_pipedown,
    output logic             fadd_ex2_pipedown,
    output logic             fadd_ex3_pipedown,
    output logic [CNT_W-1:0] falu_inflight_cnt,
    output logic             falu_idle
);

    stage_t     ex1, ex2, ex3;
    stage_t     ex1_nxt, ex2_nxt, ex3_nxt;
    stage_t     new_op;
    logic       ex3_rdy;
    logic       ex1_stall, ex2_stall, ex3_stall;
    logic       issue_en;
    logic       res_take;
    owner_e     rr;
    logic [CNT_W-1:0] cnt_nxt;

    assign ex3_rdy   = owner_rdy(ex3.owner, fpu_res_rdy, vpu_res_rdy);
    assign ex3_stall = ex3.vld && !ex3_rdy;
    assign ex2_stall = ex2.vld && ex3_stall;
    assign ex1_stall = ex1.vld && ex2_stall;

    // Reset gating keeps grants low while cpurst_b is held, even though state is already clear.
    assign issue_en = !ex1_stall && !falu_flush && cpurst_b;

    aq_falu_rr_arb u_arb (
        .clk     (forever_cpuclk),
        .rst_n   (cpurst_b),
        .en      (issue_en),
        .fpu_req (fpu_req_vld),
        .vpu_req (vpu_req_vld),
        .fpu_gnt (fpu_req_gnt),
        .vpu_gnt (vpu_req_gnt),
        .rr      (rr)
    );

    always_comb begin
        new_op.vld   = fpu_req_gnt || vpu_req_gnt;
        new_op.owner = vpu_req_gnt ? OWN_VPU : OWN_FPU;
        new_op.tag   = vpu_req_gnt ? vpu_req_tag : fpu_req_tag;
    end

    // A stage refills whenever it is not stalled; an invalid upstream stage simply empties it.
    always_comb begin
        ex1_nxt = ex1;
        ex2_nxt = ex2;
        ex3_nxt = ex3;
        if (!ex3_stall) ex3_nxt = ex2;
        if (!ex2_stall) ex2_nxt = ex1;
        if (!ex1_stall) ex1_nxt = new_op;
        if (falu_flush) begin
            ex1_nxt.vld = 1'b0;
            ex2_nxt.vld = 1'b0;
            ex3_nxt.vld = 1'b0;
        end
        cnt_nxt = CNT_W'(ex1_nxt.vld) + CNT_W'(ex2_nxt.vld) + CNT_W'(ex3_nxt.vld);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex1               <= '0;
            ex2               <= '0;
            ex3               <= '0;
            falu_inflight_cnt <= '0;
        end else begin
            ex1               <= ex1_nxt;
            ex2               <= ex2_nxt;
            ex3               <= ex3_nxt;
            falu_inflight_cnt <= cnt_nxt;
        end
    end

    assign res_take    = ex3.vld && ex3_rdy && !falu_flush;
    assign fpu_res_vld = res_take && (ex3.owner == OWN_FPU);
    assign vpu_res_vld = res_take && (ex3.owner == OWN_VPU);
    assign res_tag     = ex3.tag;

    assign fadd_ex1_pipedown = (ex1.vld && !ex2_stall) || ifu_vpu_warm_up;
    assign fadd_ex2_pipedown = (ex2.vld && !ex3_stall) || ifu_vpu_warm_up;
    assign fadd_ex3_pipedown = (ex3.vld && ex3_rdy) || ifu_vpu_warm_up;

    assign falu_idle = (falu_inflight_cnt == '0) && !fpu_req_vld && !vpu_req_vld;

endmodule
